// File: rtl/sync_fifo_stream_adapter.sv
// rtl/sync_fifo_stream_adapter.sv - FIFO read-port to registered valid/ready stream adapter
// Reads are issued from buffer occupancy alone, so m_ready_i never reaches fifo_read_o.
module sync_fifo_stream_adapter #(
    parameter int DATA_WIDTH = 32,
    parameter int RD_LATENCY = 1,
    parameter int BUF_DEPTH  = 2 + RD_LATENCY,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                           clk_i,
    input  logic                           rst_n_i,
    input  logic                           flush_i,
    input  logic                           fifo_empty_i,
    input  logic [DATA_WIDTH-1:0]          fifo_rd_data_i,
    output logic                           fifo_read_o,
    output logic                           m_valid_o,
    output logic [DATA_WIDTH-1:0]          m_data_o,
    input  logic                           m_ready_i,
    output logic [$clog2(BUF_DEPTH+1)-1:0] words_o,
    output logic [CNT_WIDTH-1:0]           beat_cnt_o
);
    localparam int CW = $clog2(BUF_DEPTH + 1);
    localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam logic [PW-1:0] LAST_IDX  = PW'(BUF_DEPTH - 1);
    localparam logic [CW:0]   DEPTH_EXT = (CW + 1)'(BUF_DEPTH);
    localparam logic [CW-1:0] DEPTH_CNT = CW'(BUF_DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [BUF_DEPTH];
    logic [PW-1:0]         r_head;
    logic [PW-1:0]         r_tail;
    logic [CW-1:0]         r_count;
    logic                  r_inflight;
    logic                  r_valid;
    logic [CNT_WIDTH-1:0]  r_beat;

    logic                  w_inflight;
    logic                  w_read;
    logic                  w_capture;
    logic                  w_pop;
    logic [CW:0]           w_occupancy;
    logic [CW-1:0]         w_count_nxt;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_IDX) ? '0 : p + 1'b1;
    endfunction

    // A word still in the FIFO read pipeline already owns a buffer slot.
    assign w_inflight  = (RD_LATENCY == 1) ? r_inflight : 1'b0;
    assign w_occupancy = {1'b0, r_count} + (CW + 1)'(w_inflight);
    assign w_read      = !fifo_empty_i && !flush_i && rst_n_i && (w_occupancy < DEPTH_EXT);
    assign w_capture   = (RD_LATENCY == 0) ? w_read : (w_inflight && !flush_i);
    assign w_pop       = r_valid && m_ready_i && !flush_i;

    always_comb begin
        w_count_nxt = r_count;
        if (w_capture && !w_pop) begin
            w_count_nxt = r_count + 1'b1;
        end else if (!w_capture && w_pop) begin
            w_count_nxt = r_count - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_inflight <= 1'b0;
            r_valid    <= 1'b0;
            r_beat     <= '0;
        end else if (flush_i) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_inflight <= 1'b0;
            r_valid    <= 1'b0;
        end else begin
            r_inflight <= w_read;
            r_count    <= w_count_nxt;
            r_valid    <= (w_count_nxt != '0);
            if (w_capture) begin
                r_tail <= ptr_inc(r_tail);
            end
            if (w_pop) begin
                r_head <= ptr_inc(r_head);
                r_beat <= r_beat + CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_n_i && w_capture) begin
            r_mem[r_tail] <= fifo_rd_data_i;
        end
    end

    assign fifo_read_o = w_read;
    assign m_valid_o   = r_valid;
    assign m_data_o    = r_mem[r_head];
    assign words_o     = r_count;
    assign beat_cnt_o  = r_beat;

    a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_n_i)
        !(w_capture && (r_count == DEPTH_CNT)));
    a_occupancy: assert property (@(posedge clk_i) disable iff (!rst_n_i)
        w_occupancy <= DEPTH_EXT);

endmodule
